// File: rtl/ib_loader_pkg.sv
// Shared types and constants for the instruction-buffer loader.
package ib_loader_pkg;

   localparam int INST_BITS_DEF = 128;
   localparam int WORD_BITS_DEF = 32;
   localparam int ADDR_BITS_DEF = 10;
   localparam int WPI_DEF       = INST_BITS_DEF / WORD_BITS_DEF;

   // Loader FSM states, exported on the debug port.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } ib_state_t;

   // Width of the beat counter for a given number of words per instruction.
   function automatic int beat_cnt_bits(input int wpi);
      return (wpi > 1) ? $clog2(wpi) : 1;
   endfunction

   localparam int BEAT_BITS_DEF = beat_cnt_bits(WPI_DEF);

endpackage

// File: rtl/ib_loader_if.sv
// Word stream from the host DMA into the loader.
// Handshake: a beat transfers on every rising clk edge where s_tvalid and
// s_tready are both high; the master holds s_tdata/s_tlast stable while
// s_tvalid is high and not yet accepted. s_tready never depends on s_tvalid.
interface ib_loader_if #(
   parameter int WORD_BITS = 32
) ();
   logic [WORD_BITS-1:0] s_tdata;
   logic                 s_tvalid;
   logic                 s_tlast;
   logic                 s_tready;

   modport master (output s_tdata, output s_tvalid, output s_tlast, input s_tready);
   modport slave  (input s_tdata, input s_tvalid, input s_tlast, output s_tready);
endinterface

// File: rtl/ib_loader_packer.sv
// Packs WORD_BITS beats into one INST_BITS instruction, first beat in the
// least significant slot. pack_next_o is the instruction including the beat
// being accepted this cycle, so the loader can register it on the last beat.
module ib_loader_packer
   import ib_loader_pkg::*;
#(
   parameter int INST_BITS = 128,
   parameter int WORD_BITS = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 clear_i,
   input  logic                 beat_i,
   input  logic [WORD_BITS-1:0] data_i,
   output logic                 last_slot_o,
   output logic                 full_o,
   output logic [INST_BITS-1:0] pack_next_o
);

   localparam int WPI = INST_BITS / WORD_BITS;
   localparam int CW  = beat_cnt_bits(WPI);

   logic [CW-1:0]        cnt_q, cnt_d;
   logic [INST_BITS-1:0] pack_q, pack_d;

   assign last_slot_o = (cnt_q == CW'(WPI - 1));
   assign full_o      = beat_i & last_slot_o & ~clear_i;
   assign pack_next_o = pack_d;

   // Next packing register and beat counter; clear wins over a beat.
   always_comb begin
      pack_d = pack_q;
      pack_d[int'(cnt_q) * WORD_BITS +: WORD_BITS] = data_i;
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (beat_i) begin
         cnt_d = last_slot_o ? '0 : cnt_q + CW'(1);
      end
   end

   // Beat counter and packing register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q  <= '0;
         pack_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (beat_i && !clear_i) begin
            pack_q <= pack_d;
         end
      end
   end

endmodule

// File: rtl/ib_loader.sv
// Instruction-buffer loader: packs the DMA word stream into instructions and
// writes them to consecutive buffer addresses starting at load_base.
module ib_loader
   import ib_loader_pkg::*;
#(
   parameter int INST_BITS = 128,
   parameter int WORD_BITS = 32,
   parameter int ADDR_BITS = 10,
   parameter int PC_DEPTH  = 1024
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 load_start,
   input  logic [ADDR_BITS-1:0] load_base,
   input  logic [ADDR_BITS:0]   load_count,
   input  logic                 load_abort,
   ib_loader_if.slave           s_axis,
   output logic                 ib_wea,
   output logic [ADDR_BITS-1:0] ib_addra,
   output logic [INST_BITS-1:0] ib_din,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [ADDR_BITS-1:0] last_addr,
   output ib_state_t            dbg_state
);

   localparam int CNT_W = ADDR_BITS + 1;

   ib_state_t            state_q;
   logic [ADDR_BITS-1:0] base_q;
   logic [CNT_W-1:0]     count_q;
   logic [CNT_W-1:0]     idx_q;
   logic                 busy_q, done_q, tready_q, wea_q, err_q;
   logic [ADDR_BITS-1:0] addra_q, last_addr_q;
   logic [INST_BITS-1:0] din_q;

   logic                 tready, beat, last_inst, final_word, early_tlast;
   logic                 too_big, pk_clear, pk_last_slot, pk_full;
   logic [INST_BITS-1:0] pk_next;

   // Abort cancels any same-cycle beat, write or done pulse.
   assign tready          = tready_q & ~load_abort;
   assign s_axis.s_tready = tready;
   assign beat            = s_axis.s_tvalid & tready;
   assign last_inst       = (idx_q == count_q - CNT_W'(1));
   assign final_word      = last_inst & pk_last_slot;
   assign early_tlast     = beat & s_axis.s_tlast & ~final_word;
   assign too_big         = (load_count > CNT_W'(PC_DEPTH));
   assign pk_clear        = (state_q == ST_FILL) & (load_abort | early_tlast);

   ib_loader_packer #(
      .INST_BITS (INST_BITS),
      .WORD_BITS (WORD_BITS)
   ) u_packer (
      .clk         (clk),
      .reset_n     (reset_n),
      .clear_i     (pk_clear),
      .beat_i      (beat),
      .data_i      (s_axis.s_tdata),
      .last_slot_o (pk_last_slot),
      .full_o      (pk_full),
      .pack_next_o (pk_next)
   );

   // Load sequencing with registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         base_q      <= '0;
         count_q     <= '0;
         idx_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         tready_q    <= 1'b0;
         wea_q       <= 1'b0;
         err_q       <= 1'b0;
         addra_q     <= '0;
         din_q       <= '0;
         last_addr_q <= '0;
      end else begin
         done_q <= 1'b0;
         wea_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (load_start) begin
                  base_q  <= load_base;
                  count_q <= load_count;
                  idx_q   <= '0;
                  if (too_big) begin
                     err_q <= 1'b1;
                  end else begin
                     err_q       <= 1'b0;
                     last_addr_q <= load_base + load_count[ADDR_BITS-1:0] - ADDR_BITS'(1);
                     if (load_count == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                     end else begin
                        state_q  <= ST_FILL;
                        busy_q   <= 1'b1;
                        tready_q <= 1'b1;
                     end
                  end
               end
            end
            ST_FILL: begin
               if (load_abort || early_tlast) begin
                  // Partial instruction is dropped; earlier writes stay in the buffer.
                  state_q  <= ST_IDLE;
                  busy_q   <= 1'b0;
                  tready_q <= 1'b0;
                  if (early_tlast) begin
                     err_q <= 1'b1;
                  end
               end else if (pk_full) begin
                  state_q  <= ST_WRITE;
                  tready_q <= 1'b0;
                  wea_q    <= 1'b1;
                  addra_q  <= base_q + idx_q[ADDR_BITS-1:0];
                  din_q    <= pk_next;
                  if (last_inst && !s_axis.s_tlast) begin
                     err_q <= 1'b1;
                  end
               end
            end
            ST_WRITE: begin
               if (load_abort) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  idx_q <= idx_q + CNT_W'(1);
                  if (last_inst) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q  <= ST_FILL;
                     tready_q <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign ib_wea    = wea_q & ~load_abort;
   assign ib_addra  = addra_q;
   assign ib_din    = din_q;
   assign busy      = busy_q;
   assign done      = done_q & ~load_abort;
   assign err       = err_q;
   assign last_addr = last_addr_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_ib_loader.sv
// Bench for ib_loader: directed and random loads, each cycle compared against
// a transaction-level model of the loader built from its load/beat rules.
module tb_ib_loader;
   import ib_loader_pkg::*;

   localparam int INST_BITS = 128;
   localparam int WORD_BITS = 32;
   localparam int ADDR_BITS = 10;
   localparam int PC_DEPTH  = 1024;
   localparam int WPI       = INST_BITS / WORD_BITS;

   // ---------------- clock / reset / DUT ----------------
   logic                 clk = 1'b0;
   logic                 reset_n = 1'b0;
   logic                 load_start = 1'b0;
   logic [ADDR_BITS-1:0] load_base = '0;
   logic [ADDR_BITS:0]   load_count = '0;
   logic                 load_abort = 1'b0;
   logic                 ib_wea, busy, done, err;
   logic [ADDR_BITS-1:0] ib_addra, last_addr;
   logic [INST_BITS-1:0] ib_din;
   ib_state_t            dbg_state;

   ib_loader_if #(.WORD_BITS(WORD_BITS)) s_if ();

   always #5 clk = ~clk;

   ib_loader #(
      .INST_BITS (INST_BITS),
      .WORD_BITS (WORD_BITS),
      .ADDR_BITS (ADDR_BITS),
      .PC_DEPTH  (PC_DEPTH)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_start (load_start),
      .load_base  (load_base),
      .load_count (load_count),
      .load_abort (load_abort),
      .s_axis     (s_if),
      .ib_wea     (ib_wea),
      .ib_addra   (ib_addra),
      .ib_din     (ib_din),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .last_addr  (last_addr),
      .dbg_state  (dbg_state)
   );

   // ---------------- scoreboard bookkeeping ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [INST_BITS-1:0] act,
                        input logic [INST_BITS-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   logic [ADDR_BITS+INST_BITS-1:0] exp_q[$];
   logic [ADDR_BITS-1:0]           wr_addr_log[$];
   logic [INST_BITS-1:0]           wr_data_log[$];
   int                             done_cnt = 0;

   // Model of the loader: a load is active from start until its last write,
   // a write follows every WPI accepted beats, done follows the last write.
   bit                   m_active, m_wpend, m_dpend, m_err;
   logic [ADDR_BITS-1:0] m_base, m_last;
   int                   m_count, m_beats, m_insts;
   logic [INST_BITS-1:0] m_pack;

   always @(negedge clk) begin
      bit fin;
      if (!reset_n) begin
         m_active = 0; m_wpend = 0; m_dpend = 0; m_err = 0;
         m_base = '0; m_last = '0; m_count = 0; m_beats = 0; m_insts = 0; m_pack = '0;
         exp_q.delete();
         check("reset_ctl", {ib_wea, busy, done, err, s_if.s_tready}, '0);
         check("reset_addr", {last_addr, ib_addra}, '0);
         check("reset_din", ib_din, '0);
      end else begin
         // compare this cycle
         check("busy", busy, m_active);
         check("tready", s_if.s_tready, m_active && !m_wpend && !load_abort);
         check("wea", ib_wea, m_wpend && !load_abort);
         check("done", done, m_dpend && !load_abort);
         check("err", err, m_err);
         check("last_addr", last_addr, m_last);
         if (m_wpend && !load_abort) begin
            if (exp_q.size() == 0) check("exp_q_empty", 1'b1, 1'b0);
            else begin
               check("ib_addra", ib_addra, exp_q[0][ADDR_BITS+INST_BITS-1 -: ADDR_BITS]);
               check("ib_din", ib_din, exp_q[0][INST_BITS-1:0]);
            end
         end
         if (ib_wea) begin
            wr_addr_log.push_back(ib_addra);
            wr_data_log.push_back(ib_din);
         end
         if (done) done_cnt++;
         // advance the model with this cycle's inputs
         if (load_abort && (m_active || m_dpend)) begin
            if (m_wpend && exp_q.size() > 0) void'(exp_q.pop_front());
            m_active = 0; m_wpend = 0; m_dpend = 0; m_beats = 0;
         end else if (m_dpend) begin
            m_dpend = 0;
         end else if (m_wpend) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            m_wpend = 0;
            m_insts++;
            if (m_insts == m_count) begin
               m_active = 0;
               m_dpend  = 1;
            end
         end else if (m_active) begin
            if (s_if.s_tvalid) begin
               fin = (m_beats == m_count * WPI - 1);
               if (s_if.s_tlast && !fin) begin
                  m_err = 1; m_active = 0; m_beats = 0;
               end else begin
                  m_pack[(m_beats % WPI) * WORD_BITS +: WORD_BITS] = s_if.s_tdata;
                  m_beats++;
                  if (m_beats % WPI == 0) begin
                     exp_q.push_back({m_base + ADDR_BITS'(m_beats / WPI - 1), m_pack});
                     m_wpend = 1;
                     if (fin && !s_if.s_tlast) m_err = 1;
                  end
               end
            end
         end else if (load_start) begin
            if (int'(load_count) > PC_DEPTH) begin
               m_err = 1;
            end else begin
               m_err   = 0;
               m_last  = ADDR_BITS'(load_base + load_count[ADDR_BITS-1:0] - 1'b1);
               m_base  = load_base;
               m_count = int'(load_count);
               m_beats = 0;
               m_insts = 0;
               if (m_count == 0) m_dpend = 1;
               else m_active = 1;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_logs();
      wr_addr_log.delete();
      wr_data_log.delete();
      done_cnt = 0;
   endtask

   task automatic start_load(input int base, input int count);
      load_start = 1'b1;
      load_base  = ADDR_BITS'(base);
      load_count = (ADDR_BITS+1)'(count);
      @(posedge clk); #1;
      load_start = 1'b0;
   endtask

   task automatic send_beat(input logic [WORD_BITS-1:0] d, input bit last, input int gap);
      bit ok;
      int n;
      repeat (gap) begin @(posedge clk); #1; end
      s_if.s_tdata  = d;
      s_if.s_tvalid = 1'b1;
      s_if.s_tlast  = last;
      n  = 0;
      ok = 1'b0;
      do begin
         @(negedge clk);
         ok = s_if.s_tready;
         @(posedge clk); #1;
         n++;
      end while (!ok && n < 100);
      check("beat_accept", ok, 1'b1);
      s_if.s_tvalid = 1'b0;
      s_if.s_tlast  = 1'b0;
   endtask

   // gap_mode: 0 back-to-back, 1 valid every other cycle, 2 random gaps
   task automatic send_stream(input int n, input int tlast_at, input int gap_mode, input bit seq);
      for (int k = 0; k < n; k++) begin
         int gap;
         gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? ((k == 0) ? 0 : 1) : $urandom_range(0, 2);
         send_beat(seq ? WORD_BITS'(k + 1) : WORD_BITS'($urandom), (k == tlast_at), gap);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(posedge clk); #1;
      while (dbg_state != ST_IDLE && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      check("idle_timeout", (dbg_state == ST_IDLE), 1'b1);
      repeat (2) begin @(posedge clk); #1; end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      s_if.s_tdata  = '0;
      s_if.s_tvalid = 1'b0;
      s_if.s_tlast  = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      check("post_reset_err", err, 1'b0);

      // two instructions from address 0, sequential beats
      clear_logs();
      start_load(0, 2);
      send_stream(8, 7, 0, 1);
      wait_idle();
      check("t1_writes", wr_addr_log.size(), 2);
      if (wr_addr_log.size() == 2) begin
         check("t1_addr0", wr_addr_log[0], 0);
         check("t1_din0", wr_data_log[0], 128'h00000004_00000003_00000002_00000001);
         check("t1_addr1", wr_addr_log[1], 1);
         check("t1_din1", wr_data_log[1], 128'h00000008_00000007_00000006_00000005);
      end
      check("t1_done", done_cnt, 1);
      check("t1_last_addr", last_addr, 1);
      check("t1_err", err, 1'b0);

      // address wrap at the top of the buffer
      clear_logs();
      start_load(1022, 4);
      send_stream(16, 15, 0, 0);
      wait_idle();
      check("t2_writes", wr_addr_log.size(), 4);
      if (wr_addr_log.size() == 4) begin
         check("t2_addr0", wr_addr_log[0], 1022);
         check("t2_addr1", wr_addr_log[1], 1023);
         check("t2_addr2", wr_addr_log[2], 0);
         check("t2_addr3", wr_addr_log[3], 1);
      end
      check("t2_last_addr", last_addr, 1);

      // early tlast on beat 3 of a two-instruction load
      clear_logs();
      start_load(5, 2);
      send_stream(3, 2, 0, 1);
      wait_idle();
      check("t3_writes", wr_addr_log.size(), 0);
      check("t3_err", err, 1'b1);
      check("t3_done", done_cnt, 0);
      check("t3_busy", busy, 1'b0);

      // missing tlast on the final beat, then a clean load clears err
      clear_logs();
      start_load(7, 1);
      send_stream(4, -1, 0, 1);
      wait_idle();
      check("t4_writes", wr_addr_log.size(), 1);
      if (wr_addr_log.size() == 1) check("t4_addr", wr_addr_log[0], 7);
      check("t4_done", done_cnt, 1);
      check("t4_err", err, 1'b1);
      start_load(8, 1);
      check("t4_err_cleared", err, 1'b0);
      send_stream(4, 3, 0, 0);
      wait_idle();

      // valid toggled every other cycle
      clear_logs();
      start_load(100, 3);
      send_stream(12, 11, 1, 1);
      wait_idle();
      check("t5_writes", wr_addr_log.size(), 3);
      if (wr_addr_log.size() == 3)
         check("t5_din2", wr_data_log[2], 128'h0000000c_0000000b_0000000a_00000009);
      check("t5_done", done_cnt, 1);

      // abort on the third beat of instruction 1
      clear_logs();
      start_load(200, 3);
      send_stream(4, -1, 0, 0);
      send_stream(2, -1, 0, 0);
      s_if.s_tdata  = 32'hdead_beef;
      s_if.s_tvalid = 1'b1;
      load_abort    = 1'b1;
      @(posedge clk); #1;
      load_abort    = 1'b0;
      s_if.s_tvalid = 1'b0;
      wait_idle();
      check("t6_writes", wr_addr_log.size(), 1);
      check("t6_done", done_cnt, 0);
      check("t6_err", err, 1'b0);

      // asynchronous reset in the middle of a fill, then a clean load
      start_load(300, 2);
      send_stream(2, -1, 0, 0);
      #2 reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      clear_logs();
      start_load(400, 2);
      send_stream(8, 7, 0, 1);
      wait_idle();
      check("t7_writes", wr_addr_log.size(), 2);
      if (wr_addr_log.size() == 2) check("t7_addr1", wr_addr_log[1], 401);

      // oversize count and zero count
      start_load(10, PC_DEPTH + 1);
      repeat (2) begin @(posedge clk); #1; end
      check("t8_oversize_err", err, 1'b1);
      check("t8_oversize_busy", busy, 1'b0);
      clear_logs();
      start_load(50, 0);
      wait_idle();
      check("t8_zero_done", done_cnt, 1);
      check("t8_zero_writes", wr_addr_log.size(), 0);
      check("t8_zero_last", last_addr, 49);

      // random loads, occasionally a start request while busy or a missing tlast
      for (int i = 0; i < 20; i++) begin
         int cnt, tl;
         cnt = $urandom_range(1, 4);
         tl  = ($urandom_range(0, 5) == 0) ? -1 : cnt * WPI - 1;
         start_load($urandom_range(0, PC_DEPTH - 1), cnt);
         if (i % 5 == 0) begin
            load_start = 1'b1;
            load_base  = ADDR_BITS'($urandom);
            load_count = (ADDR_BITS+1)'($urandom_range(1, 8));
            send_beat(WORD_BITS'($urandom), 1'b0, 0);
            load_start = 1'b0;
            send_stream(cnt * WPI - 1, tl - 1, 2, 0);
         end else begin
            send_stream(cnt * WPI, tl, 2, 0);
         end
         wait_idle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
